// File: rtl/button_event_unit.sv
// -----------------------------------------------------------------------------
// button_event_unit
//
// N-channel button conditioner. One prescaler produces a timebase tick that all
// channels share. Each channel has a two-flop synchronizer, a tick-based
// debounce, registered press/release pulses, and an optional auto-repeat
// generator that runs while the button is held.
//
// Ports
//   clock        in   1     system clock
//   resetn       in   1     asynchronous active-low reset
//   btn_raw      in   N_CH  unsynchronised button pins
//   repeat_en    in   N_CH  per-channel auto-repeat enable
//   level        out  N_CH  debounced pressed state (1 = pressed)
//   press        out  N_CH  one-cycle pulse when level rises
//   release_evt  out  N_CH  one-cycle pulse when level falls
//   repeat_evt   out  N_CH  one-cycle auto-repeat pulse
//   any_event    out  1     OR of every press/release/repeat bit, same cycle
//   tick_out     out  1     one-cycle timebase tick
//
// Auto-repeat states (one FSM per channel)
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   RP_UP    | debounced level is 0, nothing to time
//   RP_WAIT  | held; counting the initial delay (held at 0 while repeat_en = 0)
//   RP_RPT   | held past the delay; a pulse every REPEAT_RATE_TICKS ticks
// -----------------------------------------------------------------------------
module button_event_unit #(
    parameter int N_CH               = 4,
    parameter int CLK_HZ             = 50_000_000,
    parameter int TICK_HZ            = 1000,
    parameter int DEBOUNCE_TICKS     = 20,
    parameter int REPEAT_DELAY_TICKS = 500,
    parameter int REPEAT_RATE_TICKS  = 100,
    parameter int ACTIVE_LOW         = 1,
    parameter int CNT_W              = 16
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [N_CH-1:0] btn_raw,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_evt,
    output logic [N_CH-1:0] repeat_evt,
    output logic            any_event,
    output logic            tick_out
);

    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int PRE_W     = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int MAX_A     = (DEBOUNCE_TICKS > REPEAT_DELAY_TICKS) ? DEBOUNCE_TICKS
                                                                     : REPEAT_DELAY_TICKS;
    localparam int MAX_TICKS = (MAX_A > REPEAT_RATE_TICKS) ? MAX_A : REPEAT_RATE_TICKS;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY_TICKS - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE_TICKS - 1);
    // Pin value of a released button; also the synchronizer reset value.
    localparam logic [N_CH-1:0]  PIN_IDLE  = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

    if (DIV < 2) begin : g_div_chk
        $error("button_event_unit: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (DEBOUNCE_TICKS < 1 || REPEAT_DELAY_TICKS < 1 || REPEAT_RATE_TICKS < 1) begin : g_tick_chk
        $error("button_event_unit: tick parameters must be at least 1");
    end
    if (CNT_W <= $clog2(MAX_TICKS)) begin : g_width_chk
        $error("button_event_unit: CNT_W too narrow for the largest tick parameter");
    end

    typedef enum logic [1:0] {
        RP_UP   = 2'd0,
        RP_WAIT = 2'd1,
        RP_RPT  = 2'd2
    } rp_state_e;

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [N_CH-1:0]  sync1_q, sync1_d;
    logic [N_CH-1:0]  sync2_q, sync2_d;
    logic [N_CH-1:0]  level_q, level_d;
    logic [N_CH-1:0]  press_q, press_d;
    logic [N_CH-1:0]  release_q, release_d;
    logic [N_CH-1:0]  repeat_q, repeat_d;
    logic             any_event_q, any_event_d;
    logic [CNT_W-1:0] db_cnt_q [N_CH];
    logic [CNT_W-1:0] db_cnt_d [N_CH];
    logic [CNT_W-1:0] rp_cnt_q [N_CH];
    logic [CNT_W-1:0] rp_cnt_d [N_CH];
    rp_state_e        rp_state_q [N_CH];
    rp_state_e        rp_state_d [N_CH];

    logic             tick;
    logic [N_CH-1:0]  pressed_s;

    assign tick      = (presc_q == PRE_LAST);
    assign pressed_s = sync2_q ^ PIN_IDLE;

    always_comb begin
        presc_d  = tick ? '0 : presc_q + PRE_W'(1);
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        level_d  = level_q;
        repeat_d = '0;

        for (int ch = 0; ch < N_CH; ch++) begin
            db_cnt_d[ch]   = db_cnt_q[ch];
            rp_cnt_d[ch]   = rp_cnt_q[ch];
            rp_state_d[ch] = rp_state_q[ch];

            // Any cycle where the input agrees with the level throws away
            // partial progress, so a bounce restarts the count.
            if (pressed_s[ch] == level_q[ch]) begin
                db_cnt_d[ch] = '0;
            end else if (tick) begin
                if (db_cnt_q[ch] == DB_LAST) begin
                    level_d[ch]  = pressed_s[ch];
                    db_cnt_d[ch] = '0;
                end else begin
                    db_cnt_d[ch] = db_cnt_q[ch] + CNT_W'(1);
                end
            end
        end

        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;

        for (int ch = 0; ch < N_CH; ch++) begin
            // A falling level overrides everything, so release beats a due repeat.
            if (release_d[ch]) begin
                rp_state_d[ch] = RP_UP;
                rp_cnt_d[ch]   = '0;
            end else begin
                case (rp_state_q[ch])
                    RP_UP: begin
                        if (press_d[ch]) begin
                            rp_state_d[ch] = RP_WAIT;
                            rp_cnt_d[ch]   = '0;
                        end
                    end
                    RP_WAIT: begin
                        if (!repeat_en[ch]) begin
                            rp_cnt_d[ch] = '0;
                        end else if (tick) begin
                            if (rp_cnt_q[ch] == DLY_LAST) begin
                                repeat_d[ch]   = 1'b1;
                                rp_cnt_d[ch]   = '0;
                                rp_state_d[ch] = RP_RPT;
                            end else begin
                                rp_cnt_d[ch] = rp_cnt_q[ch] + CNT_W'(1);
                            end
                        end
                    end
                    RP_RPT: begin
                        // Dropping the enable goes back to WAIT so re-enabling
                        // restarts the full initial delay.
                        if (!repeat_en[ch]) begin
                            rp_cnt_d[ch]   = '0;
                            rp_state_d[ch] = RP_WAIT;
                        end else if (tick) begin
                            if (rp_cnt_q[ch] == RATE_LAST) begin
                                repeat_d[ch] = 1'b1;
                                rp_cnt_d[ch] = '0;
                            end else begin
                                rp_cnt_d[ch] = rp_cnt_q[ch] + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        rp_state_d[ch] = RP_UP;
                        rp_cnt_d[ch]   = '0;
                    end
                endcase
            end
        end

        any_event_d = |{press_d, release_d, repeat_d};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            presc_q     <= '0;
            sync1_q     <= PIN_IDLE;
            sync2_q     <= PIN_IDLE;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            repeat_q    <= '0;
            any_event_q <= 1'b0;
            for (int ch = 0; ch < N_CH; ch++) begin
                db_cnt_q[ch]   <= '0;
                rp_cnt_q[ch]   <= '0;
                rp_state_q[ch] <= RP_UP;
            end
        end else begin
            presc_q     <= presc_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
            any_event_q <= any_event_d;
            for (int ch = 0; ch < N_CH; ch++) begin
                db_cnt_q[ch]   <= db_cnt_d[ch];
                rp_cnt_q[ch]   <= rp_cnt_d[ch];
                rp_state_q[ch] <= rp_state_d[ch];
            end
        end
    end

    assign level       = level_q;
    assign press       = press_q;
    assign release_evt = release_q;
    assign repeat_evt  = repeat_q;
    assign any_event   = any_event_q;
    assign tick_out    = tick;

endmodule

// File: tb/tb_button_event_unit.sv
// -----------------------------------------------------------------------------
// Bench for button_event_unit with DIV = 10, DEBOUNCE = 3, DELAY = 5, RATE = 2.
// cyc counts rising edges since reset release; ticks occur in cycles with
// cyc % 10 == 9, so every debounced event becomes visible at a cyc multiple of
// 10. A raw change driven just after the sample at cyc = 10m+1 settles into a
// level change visible at cyc = 10(m+3).
// -----------------------------------------------------------------------------
module tb_button_event_unit;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] btn_raw = 4'b1111;
    logic [3:0] repeat_en = 4'b0000;
    logic [3:0] level, press, release_evt, repeat_evt;
    logic       any_event, tick_out;

    always #5 clock = ~clock;

    button_event_unit #(
        .N_CH(4), .CLK_HZ(100), .TICK_HZ(10), .DEBOUNCE_TICKS(3),
        .REPEAT_DELAY_TICKS(5), .REPEAT_RATE_TICKS(2), .ACTIVE_LOW(1), .CNT_W(16)
    ) dut (
        .clock(clock), .resetn(resetn), .btn_raw(btn_raw), .repeat_en(repeat_en),
        .level(level), .press(press), .release_evt(release_evt), .repeat_evt(repeat_evt),
        .any_event(any_event), .tick_out(tick_out)
    );

    int cyc;
    always @(posedge clock or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    typedef struct {
        int       cyc;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] rp;
        logic [3:0] lv;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    logic [3:0] exp_level = 4'b0000;
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at cyc %0d: got 0x%0h, expected 0x%0h", nm, cyc, got, want);
        end
    endtask

    task automatic push(input int c, input logic [3:0] pr, input logic [3:0] rl,
                        input logic [3:0] rp, input logic [3:0] lv);
        ev_t e;
        e.cyc = c; e.pr = pr; e.rl = rl; e.rp = rp; e.lv = lv;
        exp_q.push_back(e);
    endtask

    task automatic at_cyc(input int n);
        do @(negedge clock); while (cyc != n);
        #1;
    endtask

    // Monitor: pops an expectation whenever the DUT shows any pulse.
    always @(negedge clock) begin
        if (!resetn) begin
            chk("reset_outputs", {22'd0, level, press, release_evt, repeat_evt, any_event, tick_out}, 32'd0);
            exp_level = 4'b0000;
        end else begin
            chk("tick_out", {31'd0, tick_out}, {31'd0, (cyc % 10) == 9});
            if ((press | release_evt | repeat_evt) != 4'b0000 || any_event) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {19'd0, press, release_evt, repeat_evt, any_event}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_cycle", cyc, mon_e.cyc);
                    chk("press",       {28'd0, press},       {28'd0, mon_e.pr});
                    chk("release",     {28'd0, release_evt}, {28'd0, mon_e.rl});
                    chk("repeat",      {28'd0, repeat_evt},  {28'd0, mon_e.rp});
                    chk("level_evt",   {28'd0, level},       {28'd0, mon_e.lv});
                    chk("any_event",   {31'd0, any_event},   32'd1);
                    exp_level = mon_e.lv;
                end
            end else begin
                chk("level_hold", {28'd0, level}, {28'd0, exp_level});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clock);
        #1 resetn = 1'b1;

        // Clean press and release on channel 0.
        at_cyc(11);  btn_raw[0] = 1'b0; push(40, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
        at_cyc(61);  btn_raw[0] = 1'b1; push(90, 4'b0000, 4'b0001, 4'b0000, 4'b0000);

        // Bounce on channel 1: two low ticks, one high tick, then steady low.
        at_cyc(101); btn_raw[1] = 1'b0;
        at_cyc(121); btn_raw[1] = 1'b1;
        at_cyc(131); btn_raw[1] = 1'b0; push(160, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
        at_cyc(171); btn_raw[1] = 1'b1; push(200, 4'b0000, 4'b0010, 4'b0000, 4'b0000);

        // Auto-repeat on channel 2, released on a tick where a repeat is due.
        at_cyc(201); repeat_en[2] = 1'b1;
        at_cyc(211); btn_raw[2] = 1'b0;
        push(240, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        for (int k = 0; k < 7; k++) push(290 + 20 * k, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
        at_cyc(401); btn_raw[2] = 1'b1; push(430, 4'b0000, 4'b0100, 4'b0000, 4'b0000);

        // Channel 3: repeat_en dropped mid-repeat, then restored.
        at_cyc(441); repeat_en[3] = 1'b1; btn_raw[3] = 1'b0;
        push(470, 4'b1000, 4'b0000, 4'b0000, 4'b1000);
        for (int k = 0; k < 3; k++) push(520 + 20 * k, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
        at_cyc(561); repeat_en[3] = 1'b0;
        at_cyc(601); repeat_en[3] = 1'b1;
        for (int k = 0; k < 4; k++) push(650 + 20 * k, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
        at_cyc(691); btn_raw[3] = 1'b1; push(720, 4'b0000, 4'b1000, 4'b0000, 4'b0000);

        // Simultaneous press on channels 0 and 3, then reset while held.
        at_cyc(725); repeat_en = 4'b0000;
        at_cyc(731); btn_raw[0] = 1'b0; btn_raw[3] = 1'b0;
        push(760, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
        at_cyc(785);
        chk("queue_before_reset", exp_q.size(), 32'd0);
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        #1 resetn = 1'b1;
        push(30, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
        at_cyc(41); btn_raw[0] = 1'b1; btn_raw[3] = 1'b1;
        push(70, 4'b0000, 4'b1001, 4'b0000, 4'b0000);

        at_cyc(100);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/button_event_unit.md
Name: button_event_unit

Overview:
- Parametrised N-channel input conditioner for the game buttons. It replaces the inline free-running clock divider and the raw ~KEY assignments at top level.
- Generates a shared timebase tick from the system clock. Each channel then gets a two-flop synchronizer, tick-based debounce, single-cycle press/release pulses, and optional auto-repeat while held.
- Its outputs feed the processor's button inputs and the event LEDs.

Parameters:
N_CH, 4, number of button channels
CLK_HZ, 50000000, system clock frequency
TICK_HZ, 1000, debounce/repeat timebase rate; DIV = CLK_HZ/TICK_HZ, and DIV must be >= 2
DEBOUNCE_TICKS, 20, ticks an input must stay changed before the level flips (>= 1)
REPEAT_DELAY_TICKS, 500, held ticks before the first repeat pulse (>= 1)
REPEAT_RATE_TICKS, 100, ticks between subsequent repeat pulses (>= 1)
ACTIVE_LOW, 1, 1 means raw input 0 = pressed (KEY style)
CNT_W, 16, width of the per-channel debounce and repeat counters

Ports:
clock  input  1  system clock
resetn  input  1  asynchronous active-low reset
btn_raw  input  N_CH  unsynchronised button pins
repeat_en  input  N_CH  per-channel auto-repeat enable
level  output  N_CH  debounced pressed state (1 = pressed)
press  output  N_CH  one-cycle pulse on debounced press
release  output  N_CH  one-cycle pulse on debounced release
repeat  output  N_CH  one-cycle auto-repeat pulse
any_event  output  1  OR of all press, release and repeat bits in the same cycle
tick_out  output  1  one-cycle timebase tick

Behaviour:
- Reset is asynchronous on resetn low. While reset is held:
  - Prescaler = 0, tick_out = 0.
  - Synchronizer flops = inactive pin value (1 if ACTIVE_LOW, else 0).
  - level, press, release, repeat, any_event = 0; all counters = 0; every channel in UP.
- Reset mid-press: level drops to 0 with no release pulse. After reset deassertion a still-held button must re-debounce and produces a fresh press.
- Prescaler counts 0..DIV-1 and wraps to 0. tick_out = 1 for exactly the one cycle in which the count equals DIV-1.
- Synchronizer: two flops per channel. The normalised value s = sync2 XOR ACTIVE_LOW, so s = 1 means pressed.
- Debounce counter db_cnt, per channel, evaluated every clock:
  - If s == level, db_cnt <= 0.
  - Else, on tick: if db_cnt == DEBOUNCE_TICKS-1, then level <= s and db_cnt <= 0; otherwise db_cnt++.
  - A bounce back to the old value before the threshold discards the progress.
- press / release:
  - Registered; asserted on the same edge that level rises / falls; high for exactly one cycle.
  - They never assert together on one channel.
- Auto-repeat state machine per channel, with counter rp_cnt:
  - UP: level 0. On a level rise, go to WAIT with rp_cnt = 0.
  - WAIT: on tick, rp_cnt++. When a tick arrives with rp_cnt == REPEAT_DELAY_TICKS-1 and repeat_en = 1: pulse repeat, rp_cnt <= 0, go to RPT.
  - RPT: on tick, rp_cnt++. When a tick arrives with rp_cnt == REPEAT_RATE_TICKS-1: pulse repeat, rp_cnt <= 0.
  - Any state: a level fall goes to UP and clears rp_cnt. The release pulse is emitted and repeat is suppressed in that cycle (release wins).
  - repeat_en = 0 while in WAIT or RPT: go to WAIT, rp_cnt <= 0, no repeat pulses. Re-enabling restarts the full delay.
  - A repeat never coincides with a press on the same channel.
- Latency from a raw edge to press/release: 2 clocks of synchronizer, plus DEBOUNCE_TICKS ticks, plus 1 register clock.
- Channels are fully independent. Simultaneous events on different channels all pulse in the same cycle.
- any_event is registered, aligned with the pulses.
- Counters saturate-free by construction: width CNT_W must exceed clog2 of the largest tick parameter, checked by an elaboration assertion.

Test Plan:
Common bench parameters: CLK_HZ=100, TICK_HZ=10 (DIV=10), DEBOUNCE_TICKS=3, REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2, ACTIVE_LOW=1, N_CH=4.

1. Free run after reset → tick_out pulses at cycles 9, 19, 29…, each exactly one cycle wide; all outputs are 0 during reset.
2. Hold btn_raw[0] = 0 cleanly → level[0] rises on the third tick after the synchronised edge, with press[0] high for one cycle on that same edge. On returning to 1 → symmetric release[0] after 3 ticks.
3. Bounce channel 1: low for 2 ticks, high for 1 tick, then low steady → no press until 3 consecutive low ticks. Exactly one press[1]; level never glitches.
4. Hold channel 2 with repeat_en[2] = 1 for 20 ticks → first repeat[2] 5 ticks after press, then one every 2 ticks. Release on a repeat-due tick → release[2] only, no repeat.
5. Hold channel 3 with repeat_en toggled 1→0→1 mid-RPT → no repeats while 0; the first repeat after re-enable comes 5 ticks later.
6. Press channels 0 and 3 on identical edges; assert resetn low mid-hold → simultaneous press pulses and any_event = 1 for one cycle. Reset clears level without a release; a fresh press follows 3 ticks after reset deassertion.
